window_gen_3x3: RTL and testbench

- Upstream stage of the 3x3 convolution kernels, e.g. the horizontal line detector.
- Accepts a raster-order pixel stream (one pixel per accepted beat, row-major) and buffers two full image lines.
- Emits, per accepted pixel, the complete 3x3 neighbourhood as nine 8-bit outputs p1..p9 that connect directly to a kernel's p1..p9 inputs.
- Valid/ready on both sides; no border padding, so only fully populated windows are emitted.

---
 rtl/window_pkg.sv | 26 ++
 rtl/window_gen_3x3_line_buffer.sv | 27 ++
 rtl/window_gen_3x3.sv | 165 ++++++++++++++++
 tb/tb_window_gen_3x3.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// Shared definitions for the 3x3 window generator: default pixel width,
// coordinate-width helper and the row-major tap order of the window.
package window_pkg;

   localparam int PIX_W_DEF = 8;
   localparam int WIN_TAPS  = 9;

   // Window taps in row-major order: p1 p2 p3 / p4 p5 p6 / p7 p8 p9
   typedef enum logic [3:0] {
      TAP_P1 = 4'd0,
      TAP_P2 = 4'd1,
      TAP_P3 = 4'd2,
      TAP_P4 = 4'd3,
      TAP_P5 = 4'd4,
      TAP_P6 = 4'd5,
      TAP_P7 = 4'd6,
      TAP_P8 = 4'd7,
      TAP_P9 = 4'd8
   } tap_e;

   // Bits needed to hold a coordinate in 0..n-1 (never less than one bit)
   function automatic int coordW(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// One image line of pixel storage. The read is asynchronous, so the value
// seen on o_data during a write cycle is the old content (read-before-write).
module line_buffer
   import window_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic [coordW(DEPTH)-1:0]  i_addr,
   input  logic                      i_wrEn,
   input  logic [WIDTH-1:0]          i_data,
   output logic [WIDTH-1:0]          o_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Store the incoming pixel at its column; contents are never reset
   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_mem[i_addr] <= i_data;
      end
   end

   assign o_data = r_mem[i_addr];

endmodule

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers hold the previous two rows; each accepted pixel shifts the
// window one column left. Only fully populated windows are flagged valid.
// Optional macro WINDOW_LAST_EN adds out_last on the final window of a frame.
module window_gen_3x3
   import window_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int PIX_W = PIX_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [PIX_W-1:0]            in_pix,
   input  logic                        in_valid,
   input  logic                        in_sof,
   output logic                        in_ready,
   output logic [PIX_W-1:0]            p1,
   output logic [PIX_W-1:0]            p2,
   output logic [PIX_W-1:0]            p3,
   output logic [PIX_W-1:0]            p4,
   output logic [PIX_W-1:0]            p5,
   output logic [PIX_W-1:0]            p6,
   output logic [PIX_W-1:0]            p7,
   output logic [PIX_W-1:0]            p8,
   output logic [PIX_W-1:0]            p9,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [coordW(IMG_H)-1:0]    out_row,
   output logic [coordW(IMG_W)-1:0]    out_col
`ifdef WINDOW_LAST_EN
   ,
   output logic                        out_last
`endif
);

   localparam int CW = coordW(IMG_W);
   localparam int RW = coordW(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [RW-1:0]    r_row;
   logic [CW-1:0]    r_col;
   logic [PIX_W-1:0] r_win [WIN_TAPS];
   logic             r_outValid;
   logic [RW-1:0]    r_outRow;
   logic [CW-1:0]    r_outCol;
   logic             r_outLast;

   logic             w_accept;
   logic [RW-1:0]    w_curRow;
   logic [CW-1:0]    w_curCol;
   logic             w_winFull;
   logic             w_frameEnd;
   logic [PIX_W-1:0] w_lb0Data;
   logic [PIX_W-1:0] w_lb1Data;

   assign in_ready   = !r_outValid || out_ready;
   assign w_accept   = in_valid && in_ready;
   assign w_winFull  = (w_curRow >= RW'(2)) && (w_curCol >= CW'(2));
   assign w_frameEnd = (w_curRow == ROW_LAST) && (w_curCol == COL_LAST);

   // Position of the pixel on the input: start-of-frame overrides the counters
   always_comb begin
      w_curRow = r_row;
      w_curCol = r_col;
      if (in_sof) begin
         w_curRow = '0;
         w_curCol = '0;
      end
   end

   // lb1 holds the row above the current one, lb0 the row above that
   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
      .clk    (clk),
      .i_addr (w_curCol),
      .i_wrEn (w_accept),
      .i_data (in_pix),
      .o_data (w_lb1Data)
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
      .clk    (clk),
      .i_addr (w_curCol),
      .i_wrEn (w_accept),
      .i_data (w_lb1Data),
      .o_data (w_lb0Data)
   );

   // Raster position counters: column wraps into the next row, row into the next frame
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_row <= '0;
         r_col <= '0;
      end else if (w_accept) begin
         if (w_curCol == COL_LAST) begin
            r_col <= '0;
            r_row <= (w_curRow == ROW_LAST) ? '0 : w_curRow + RW'(1);
         end else begin
            r_col <= w_curCol + CW'(1);
            r_row <= w_curRow;
         end
      end
   end

   // Shift the window left and load the new right column on every accepted pixel
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < WIN_TAPS; k++) begin
            r_win[k] <= '0;
         end
      end else if (w_accept) begin
         r_win[TAP_P1] <= r_win[TAP_P2];
         r_win[TAP_P2] <= r_win[TAP_P3];
         r_win[TAP_P3] <= w_lb0Data;
         r_win[TAP_P4] <= r_win[TAP_P5];
         r_win[TAP_P5] <= r_win[TAP_P6];
         r_win[TAP_P6] <= w_lb1Data;
         r_win[TAP_P7] <= r_win[TAP_P8];
         r_win[TAP_P8] <= r_win[TAP_P9];
         r_win[TAP_P9] <= in_pix;
      end
   end

   // Output handshake: flag complete windows, drop valid once consumed, hold on stall
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_outValid <= 1'b0;
         r_outRow   <= '0;
         r_outCol   <= '0;
         r_outLast  <= 1'b0;
      end else if (w_accept) begin
         r_outValid <= w_winFull;
         r_outLast  <= w_winFull && w_frameEnd;
         if (w_winFull) begin
            r_outRow <= w_curRow - RW'(1);
            r_outCol <= w_curCol - CW'(1);
         end
      end else if (out_ready) begin
         r_outValid <= 1'b0;
         r_outLast  <= 1'b0;
      end
   end

   assign p1        = r_win[TAP_P1];
   assign p2        = r_win[TAP_P2];
   assign p3        = r_win[TAP_P3];
   assign p4        = r_win[TAP_P4];
   assign p5        = r_win[TAP_P5];
   assign p6        = r_win[TAP_P6];
   assign p7        = r_win[TAP_P7];
   assign p8        = r_win[TAP_P8];
   assign p9        = r_win[TAP_P9];
   assign out_valid = r_outValid;
   assign out_row   = r_outRow;
   assign out_col   = r_outCol;

`ifdef WINDOW_LAST_EN
   assign out_last  = r_outLast;
`else
   logic w_lastUnused;
   assign w_lastUnused = r_outLast;
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 on a 5x4 image: a vector table for
// the basic frame, hand-written stall / sof / reset sequences, and a random run
// compared against a frame-array reference model.
module tb_window_gen_3x3;

   localparam int W = 5;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic [7:0] inPix = '0;
   logic       inValid = 1'b0;
   logic       inSof = 1'b0;
   logic       inReady;
   logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
   logic       outValid;
   logic       outReady = 1'b1;
   logic [1:0] outRow;
   logic [2:0] outCol;
   logic       outLast;

   int nTests = 0;
   int nFail  = 0;

   // reference model state
   int  img [H][W];
   int  mPos = 0;
   bit  mValid = 0;
   bit  mLast = 0;
   int  mWin [9];
   int  mRow = 0;
   int  mCol = 0;

   // observation helpers
   int  hsCount = 0;
   int  lastCount = 0;
   int  stallSeen = 0;
   bit  lastAcc = 0;
   bit  lastInReady = 0;
   bit  firstSeen = 0;
   int  firstWin [9];

   typedef struct {
      logic [7:0] pix;
      bit         vld;
      bit         sof;
      bit         ordy;
      bit         eValid;
      logic [7:0] eP5;
      logic [7:0] eP9;
   } vec_t;

   vec_t vecs [21];

   window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
      .clk       (clk),
      .rst_n     (rstN),
      .in_pix    (inPix),
      .in_valid  (inValid),
      .in_sof    (inSof),
      .in_ready  (inReady),
      .p1        (p1),
      .p2        (p2),
      .p3        (p3),
      .p4        (p4),
      .p5        (p5),
      .p6        (p6),
      .p7        (p7),
      .p8        (p8),
      .p9        (p9),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_row   (outRow),
      .out_col   (outCol)
`ifdef WINDOW_LAST_EN
      ,
      .out_last  (outLast)
`endif
   );

`ifndef WINDOW_LAST_EN
   assign outLast = 1'b0;
`endif

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [7:0] pix, input bit vld, input bit sof,
                               input bit ordy, input bit eValid,
                               input logic [7:0] eP5, input logic [7:0] eP9);
      vec_t v;
      v.pix = pix; v.vld = vld; v.sof = sof; v.ordy = ordy;
      v.eValid = eValid; v.eP5 = eP5; v.eP9 = eP9;
      return v;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      nTests++;
      if (act != exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // compare every visible DUT output against the reference model
   task automatic checkOutput();
      int dw [9];
      dw = '{p1, p2, p3, p4, p5, p6, p7, p8, p9};
      chk("out_valid", outValid, mValid);
      if (mValid) begin
         for (int k = 0; k < 9; k++) begin
            chk($sformatf("p%0d", k + 1), dw[k], mWin[k]);
         end
         chk("out_row", outRow, mRow);
         chk("out_col", outCol, mCol);
      end
`ifdef WINDOW_LAST_EN
      chk("out_last", outLast, mValid && mLast);
`endif
   endtask

   // drive one cycle, advance the model from the specification rules, check after the edge
   task automatic applyStimulus(input logic [7:0] pix, input bit vld, input bit sof, input bit ordy);
      bit expReady;
      int r, c;
      @(negedge clk);
      inPix = pix; inValid = vld; inSof = sof; outReady = ordy;
      #1;
      expReady = !mValid || ordy;
      chk("in_ready", inReady, expReady);
      lastInReady = inReady;
      if (outValid && ordy) begin
         hsCount++;
         if (outLast) lastCount++;
         if (!firstSeen) begin
            firstWin = '{p1, p2, p3, p4, p5, p6, p7, p8, p9};
            firstSeen = 1;
         end
      end
      lastAcc = vld && expReady;
      if (lastAcc) begin
         if (sof) mPos = 0;
         r = mPos / W;
         c = mPos % W;
         img[r][c] = pix;
         if (r >= 2 && c >= 2) begin
            mValid = 1;
            for (int k = 0; k < 9; k++) mWin[k] = img[r - 2 + k / 3][c - 2 + k % 3];
            mRow = r - 1;
            mCol = c - 1;
            mLast = (r == H - 1) && (c == W - 1);
         end else begin
            mValid = 0;
            mLast = 0;
         end
         mPos = (mPos + 1) % (W * H);
      end else if (ordy) begin
         mValid = 0;
         mLast = 0;
      end
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   // one-cycle synchronous reset, then confirm all reset values
   task automatic resetDut(input logic [7:0] pix, input bit vld);
      @(negedge clk);
      rstN = 1'b0; inPix = pix; inValid = vld; inSof = 1'b0; outReady = 1'b1;
      @(posedge clk);
      #1;
      rstN = 1'b1;
      mValid = 0; mLast = 0; mPos = 0;
      chk("rst_out_valid", outValid, 0);
      chk("rst_out_row", outRow, 0);
      chk("rst_out_col", outCol, 0);
      chk("rst_p1", p1, 0);
      chk("rst_p5", p5, 0);
      chk("rst_p9", p9, 0);
`ifdef WINDOW_LAST_EN
      chk("rst_out_last", outLast, 0);
`endif
   endtask

   // feed pixels base+16r+c for raster indices first..last, optionally stalling on a window
   task automatic runPixels(input int base, input int first, input int last,
                            input bit sofFirst, input int stallP9);
      int i = first;
      int guard = 0;
      bit ordy;
      while (i <= last && guard < 200) begin
         guard++;
         ordy = 1;
         if (stallP9 >= 0 && mValid && mWin[8] == stallP9 && stallSeen < 3) begin
            ordy = 0;
            stallSeen++;
         end
         applyStimulus(8'(base + 16 * (i / W) + (i % W)), 1'b1, sofFirst && (i == first), ordy);
         if (!ordy) begin
            chk("stall_in_ready", lastInReady, 0);
            chk("stall_p9", p9, stallP9);
         end
         if (lastAcc) i++;
      end
      if (i <= last) chk("feed_timeout", i, last + 1);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      int basicWin [9];
      basicWin = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};

      vecs[0]  = mk(8'h00, 1, 1, 1, 0, 8'h00, 8'h00);
      vecs[1]  = mk(8'h01, 1, 0, 1, 0, 8'h00, 8'h00);
      vecs[2]  = mk(8'h02, 1, 0, 1, 0, 8'h00, 8'h00);
      vecs[3]  = mk(8'h03, 1, 0, 1, 0, 8'h00, 8'h00);
      vecs[4]  = mk(8'h04, 1, 0, 1, 0, 8'h00, 8'h00);
      vecs[5]  = mk(8'h10, 1, 0, 1, 0, 8'h00, 8'h00);
      vecs[6]  = mk(8'h11, 1, 0, 1, 0, 8'h00, 8'h00);
      vecs[7]  = mk(8'h12, 1, 0, 1, 0, 8'h00, 8'h00);
      vecs[8]  = mk(8'h13, 1, 0, 1, 0, 8'h00, 8'h00);
      vecs[9]  = mk(8'h14, 1, 0, 1, 0, 8'h00, 8'h00);
      vecs[10] = mk(8'h20, 1, 0, 1, 0, 8'h00, 8'h00);
      vecs[11] = mk(8'h21, 1, 0, 1, 0, 8'h00, 8'h00);
      vecs[12] = mk(8'h22, 1, 0, 1, 1, 8'h11, 8'h22);
      vecs[13] = mk(8'h23, 1, 0, 1, 1, 8'h12, 8'h23);
      vecs[14] = mk(8'h24, 1, 0, 1, 1, 8'h13, 8'h24);
      vecs[15] = mk(8'h30, 1, 0, 1, 0, 8'h00, 8'h00);
      vecs[16] = mk(8'h31, 1, 0, 1, 0, 8'h00, 8'h00);
      vecs[17] = mk(8'h32, 1, 0, 1, 1, 8'h21, 8'h32);
      vecs[18] = mk(8'h33, 1, 0, 1, 1, 8'h22, 8'h33);
      vecs[19] = mk(8'h34, 1, 0, 1, 1, 8'h23, 8'h34);
      vecs[20] = mk(8'h00, 0, 0, 1, 0, 8'h00, 8'h00);

      repeat (2) @(posedge clk);
      resetDut(8'h00, 1'b0);

      // basic frame from the vector table
      hsCount = 0; firstSeen = 0;
      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i].pix, vecs[i].vld, vecs[i].sof, vecs[i].ordy);
         chk($sformatf("tbl_valid[%0d]", i), outValid, vecs[i].eValid);
         if (vecs[i].eValid) begin
            chk($sformatf("tbl_p5[%0d]", i), p5, vecs[i].eP5);
            chk($sformatf("tbl_p9[%0d]", i), p9, vecs[i].eP9);
         end
         if (i == 12) begin
            chk("first_row", outRow, 1);
            chk("first_col", outCol, 1);
         end
         if (i == 19) begin
            chk("final_row", outRow, 2);
            chk("final_col", outCol, 3);
         end
      end
      chk("basic_windows", hsCount, 6);
      for (int k = 0; k < 9; k++) chk($sformatf("basic_win_p%0d", k + 1), firstWin[k], basicWin[k]);

      // stall on the second window
      hsCount = 0; stallSeen = 0;
      runPixels(0, 0, W * H - 1, 1'b1, 8'h23);
      chk("stall_cycles", stallSeen, 3);
      chk("stall_windows", hsCount, 6);

      // mid-frame sof at input (2,1)
      hsCount = 0;
      runPixels(0, 0, 10, 1'b1, -1);
      chk("aborted_windows", hsCount, 0);
      hsCount = 0; firstSeen = 0;
      runPixels(8'h80, 0, W * H - 1, 1'b1, -1);
      chk("sof_windows", hsCount, 6);
      chk("sof_first_p9", firstWin[8], 8'hA2);
      chk("sof_first_p1", firstWin[0], 8'h80);

      // reset arriving at input (3,2)
      runPixels(0, 0, 16, 1'b1, -1);
      resetDut(8'h32, 1'b1);
      hsCount = 0; firstSeen = 0;
      runPixels(0, 0, W * H - 1, 1'b0, -1);
      chk("postrst_windows", hsCount, 6);
      for (int k = 0; k < 9; k++) chk($sformatf("postrst_p%0d", k + 1), firstWin[k], basicWin[k]);

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         applyStimulus(8'($urandom), ($urandom % 10) < 7, ($urandom % 40) == 0, ($urandom % 10) < 7);
      end
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);

`ifdef WINDOW_LAST_EN
      // two back-to-back frames give out_last twice
      resetDut(8'h00, 1'b0);
      lastCount = 0;
      runPixels(0, 0, W * H - 1, 1'b1, -1);
      runPixels(8'h40, 0, W * H - 1, 1'b0, -1);
      chk("last_count", lastCount, 2);
`endif

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
